// File: rtl/booth_wallace_seq.sv
// Sequential signed multiplier: radix-4 Booth partial products summed five per cycle
// into a running accumulator through a 6-operand Wallace CSA tree with a final CPA.
module booth_wallace_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_product
);
  localparam int W2  = 2 * WIDTH;
  localparam int P   = WIDTH / 2;
  localparam int C   = (P + 4) / 5;
  localparam int NPP = 5 * C;
  localparam int CW  = $clog2(C + 1);
  localparam logic [CW-1:0] LAST = CW'(C - 1);

  // Handshakes: a transfer happens on the rising edge where valid && ready are both high.
  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2} state_t;

  state_t          state, state_next;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [W2-1:0]   acc;
  logic [CW-1:0]   cnt;
  logic [W2-1:0]   a_ext;
  logic [WIDTH:0]  b_ext;
  logic [W2-1:0]   pp_all [NPP];
  logic [W2-1:0]   grp [5];
  logic [W2-1:0]   s1, c1, s2, c2, s3, c3, s4, c4, sum;

  function automatic logic [W2-1:0] booth_sel(input logic [W2-1:0] a, input logic [2:0] bits);
    case (bits)
      3'b001, 3'b010: booth_sel = a;
      3'b011:         booth_sel = a << 1;
      3'b100:         booth_sel = -(a << 1);
      3'b101, 3'b110: booth_sel = -a;
      default:        booth_sel = '0;
    endcase
  endfunction

  function automatic logic [W2-1:0] maj(input logic [W2-1:0] x, y, z);
    maj = ((x & y) | (x & z) | (y & z)) << 1;
  endfunction

  assign a_ext = {{WIDTH{a_reg[WIDTH-1]}}, a_reg};
  assign b_ext = {b_reg, 1'b0};

  always_comb begin
    for (int i = 0; i < NPP; i++) pp_all[i] = '0;
    for (int i = 0; i < P; i++) pp_all[i] = booth_sel(a_ext, b_ext[2*i +: 3]) << (2 * i);
  end

  // Digits beyond the last real one read as zero, so a short final group just adds nothing.
  always_comb begin
    for (int j = 0; j < 5; j++) begin
      grp[j] = '0;
      if (5 * int'(cnt) + j < NPP) grp[j] = pp_all[5 * int'(cnt) + j];
    end
  end

  // Wallace reduction 6 -> 4 -> 3 -> 2, then one carry-propagate add.
  always_comb begin
    s1  = acc ^ grp[0] ^ grp[1];
    c1  = maj(acc, grp[0], grp[1]);
    s2  = grp[2] ^ grp[3] ^ grp[4];
    c2  = maj(grp[2], grp[3], grp[4]);
    s3  = s1 ^ c1 ^ s2;
    c3  = maj(s1, c1, s2);
    s4  = s3 ^ c3 ^ c2;
    c4  = maj(s3, c3, c2);
    sum = s4 + c4;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = ACCUM;
      ACCUM:   if (cnt == LAST) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg       <= '0;
      b_reg       <= '0;
      acc         <= '0;
      cnt         <= '0;
      out_product <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_reg <= in_a;
          b_reg <= in_b;
          acc   <= '0;
          cnt   <= '0;
        end
        ACCUM: begin
          acc <= sum;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) out_product <= sum;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
endmodule
